// File: rtl/buzzer_sched.sv
// buzzer_sched -- shares one buzzer between NUM_REQ requesters.
//
// Each requester posts a beep request with a beep count. The scheduler
// latches it and grants the buzzer round-robin. It then plays the requested
// number of beeps. Each beep is a one-cycle trigger, a wait for the buzzer's
// busy flag to rise and then fall, and a fixed silent gap before the next
// trigger. If busy never rises after a trigger, the request is aborted and
// flagged.
//
// Optional build macro:
//   BUZZER_SCHED_PRIO_EN - requester 0 is granted first whenever its request
//                          is pending at arbitration time. An in-flight
//                          sequence is never preempted.
//
// Ports:
//   clk_i        4 MHz clock
//   rst_ni       asynchronous active-low reset
//   req_i        per-requester request pulse
//   cnt_i        per-requester beep count, slice k = [k*COUNT_W +: COUNT_W]
//   pend_o       request latched and waiting for a grant
//   grant_o      one-hot, requester currently being served
//   ack_o        one-cycle pulse when a request completes or aborts
//   drop_o       one-cycle pulse when a request hits an already-pending slot
//   err_o        one-cycle pulse with ack_o when the buzzer never started
//   active_o     scheduler is not idle
//   trig_o       one-cycle trigger pulse to the buzzer
//   buzz_busy_i  buzzer cycle-in-progress flag
module buzzer_sched #(
   parameter int NUM_REQ       = 4,
   parameter int COUNT_W       = 3,
   parameter int GAP_CYCLES    = 400000,
   parameter int START_TIMEOUT = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [NUM_REQ*COUNT_W-1:0] cnt_i,
   output logic [NUM_REQ-1:0]         pend_o,
   output logic [NUM_REQ-1:0]         grant_o,
   output logic [NUM_REQ-1:0]         ack_o,
   output logic [NUM_REQ-1:0]         drop_o,
   output logic                       err_o,
   output logic                       active_o,
   output logic                       trig_o,
   input  logic                       buzz_busy_i
);

   localparam int TMAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
   localparam int TW   = $clog2(TMAX) + 1;
   localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [TW-1:0]      GAP_LAST = TW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0]      TO_LAST  = TW'(START_TIMEOUT - 1);
   localparam logic [IW-1:0]      LAST_RST = IW'(NUM_REQ - 1);
   localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_TRIG       = 3'd1,
      S_WAIT_START = 3'd2,
      S_WAIT_END   = 3'd3,
      S_GAP        = 3'd4,
      S_DONE       = 3'd5
   } state_t;

   // First pending requester found by searching upward from last+1 with
   // wrap-around. The MSB of the result is the "found" flag.
   function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] pend,
                                           input logic [IW-1:0]      last);
      logic [IW:0]   res;
      logic [IW-1:0] idx;
      res = '0;
      // Scan from the farthest offset down to the nearest one, so the
      // nearest pending requester is the last one written.
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = IW'((int'(last) + i) % NUM_REQ);
         if (pend[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
      return (t == {TW{1'b1}}) ? t : (t + TW'(1));
   endfunction

   state_t               state_r, state_s;
   logic [TW-1:0]        timer_r, timer_s;
   logic [COUNT_W-1:0]   left_r, left_s;
   logic                 abort_r, abort_s;
   logic [IW-1:0]        gidx_r, gidx_s;
   logic [IW-1:0]        last_r, last_s;
   logic                 take_s;
   logic [NUM_REQ-1:0]   pend_r, pend_s;
   logic [COUNT_W-1:0]   cnt_r [NUM_REQ];
   logic [IW:0]          pick_s;
   logic                 pick_vld_s;
   logic [IW-1:0]        pick_idx_s;
   logic [COUNT_W-1:0]   pick_cnt_s;

   logic [NUM_REQ-1:0]   grant_r, ack_r, drop_r;
   logic                 err_r, active_r, trig_r;

   // Arbitration: round-robin, optionally with requester 0 taking precedence.
   always_comb begin
`ifdef BUZZER_SCHED_PRIO_EN
      if (pend_r[0]) begin
         pick_s = {1'b1, {IW{1'b0}}};
      end else begin
         pick_s = rr_pick(pend_r, last_r);
      end
`else
      pick_s = rr_pick(pend_r, last_r);
`endif
      pick_vld_s = pick_s[IW];
      pick_idx_s = pick_s[IW-1:0];
      pick_cnt_s = cnt_r[pick_idx_s];
   end

   // Next-state logic for the beep sequencer.
   always_comb begin
      state_s = state_r;
      timer_s = timer_r;
      left_s  = left_r;
      abort_s = abort_r;
      gidx_s  = gidx_r;
      last_s  = last_r;
      take_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (pick_vld_s) begin
               take_s  = 1'b1;
               gidx_s  = pick_idx_s;
               // A stored count of zero still plays a single beep.
               left_s  = (pick_cnt_s == {COUNT_W{1'b0}}) ? CNT_ONE : pick_cnt_s;
               abort_s = 1'b0;
               state_s = S_TRIG;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_TRIG: begin
            timer_s = '0;
            state_s = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (buzz_busy_i) begin
               state_s = S_WAIT_END;
            end else if (timer_r == TO_LAST) begin
               abort_s = 1'b1;
               state_s = S_DONE;
            end else begin
               timer_s = sat_inc(timer_r);
            end
         end
         S_WAIT_END: begin
            if (!buzz_busy_i) begin
               left_s = left_r - CNT_ONE;
               if (left_r == CNT_ONE) begin
                  state_s = S_DONE;
               end else begin
                  timer_s = '0;
                  state_s = S_GAP;
               end
            end else begin
               state_s = S_WAIT_END;
            end
         end
         S_GAP: begin
            if (timer_r == GAP_LAST) begin
               state_s = S_TRIG;
            end else begin
               timer_s = sat_inc(timer_r);
            end
         end
         S_DONE: begin
            last_s  = gidx_r;
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Pending flags: set on an accepted request, cleared when granted. A
   // request arriving for an already-pending slot is dropped, so set and
   // clear never target the same bit in one cycle.
   always_comb begin
      pend_s = pend_r;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (req_i[k] && !pend_r[k]) begin
            pend_s[k] = 1'b1;
         end else if (take_s && (gidx_s == IW'(k))) begin
            pend_s[k] = 1'b0;
         end else begin
            pend_s[k] = pend_r[k];
         end
      end
   end

   // Sequencer state, timer, beep counter and arbitration pointer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= S_IDLE;
         timer_r <= '0;
         left_r  <= '0;
         abort_r <= 1'b0;
         gidx_r  <= '0;
         last_r  <= LAST_RST;
      end else begin
         state_r <= state_s;
         timer_r <= timer_s;
         left_r  <= left_s;
         abort_r <= abort_s;
         gidx_r  <= gidx_s;
         last_r  <= last_s;
      end
   end

   // Request latch: pending flags and per-requester stored beep counts.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_r <= '0;
         drop_r <= '0;
         for (int k = 0; k < NUM_REQ; k++) begin
            cnt_r[k] <= '0;
         end
      end else begin
         pend_r <= pend_s;
         drop_r <= req_i & pend_r;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (req_i[k] && !pend_r[k]) begin
               cnt_r[k] <= cnt_i[k*COUNT_W +: COUNT_W];
            end else begin
               cnt_r[k] <= cnt_r[k];
            end
         end
      end
   end

   // Registered outputs, decoded from the state being entered so that each
   // one is valid in the same cycle as that state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         grant_r  <= '0;
         ack_r    <= '0;
         err_r    <= 1'b0;
         active_r <= 1'b0;
         trig_r   <= 1'b0;
      end else begin
         grant_r  <= (state_s != S_IDLE) ? onehot(gidx_s) : {NUM_REQ{1'b0}};
         ack_r    <= (state_s == S_DONE) ? onehot(gidx_s) : {NUM_REQ{1'b0}};
         err_r    <= (state_s == S_DONE) && abort_s;
         active_r <= (state_s != S_IDLE);
         trig_r   <= (state_s == S_TRIG);
      end
   end

   assign pend_o   = pend_r;
   assign grant_o  = grant_r;
   assign ack_o    = ack_r;
   assign drop_o   = drop_r;
   assign err_o    = err_r;
   assign active_o = active_r;
   assign trig_o   = trig_r;

endmodule
